// File: rtl/rs232_tx_arbiter.sv
// -----------------------------------------------------------------------------
// rs232_tx_arbiter
//
// Shares one rs232_tx transmitter between four byte-producing requesters.
// A round-robin arbiter picks one pending requester and hands its byte to the
// transmitter over the WR_EN/DONE handshake. When the frame completes, it pulses
// the acknowledge of the requester that was granted.
//
// Ports:
//   CLK       in   1   sole clock, same clock as rs232_tx.CLK_TX
//   RST       in   1   asynchronous, active-high reset
//   REQ       in   4   request per requester, held high until its ACK
//   DATA      in  32   packed bytes, requester i uses DATA[8i+7:8i]
//   ACK       out  4   one-cycle completion pulse to the granted requester
//   GNT       out  2   index of the current or last owner
//   BUSY      out  1   high from grant until return to IDLE
//   ERR       out  1   one-cycle timeout pulse (constant 0 without the macro)
//   TX_DATA   out  8   byte to rs232_tx.DATA
//   TX_WR_EN  out  1   to rs232_tx.WR_EN
//   TX_DONE   in   1   from rs232_tx.DONE
//
// Parameter:
//   TIMEOUT   cycles allowed in SEND before the frame is abandoned (2..65535).
//             It only has an effect when the timeout option is compiled in.
//
// Optional feature (compile-time macro RS232_ARB_TIMEOUT_EN):
//   Defined   - a SEND cycle counter abandons a frame that has not seen
//               TX_DONE after TIMEOUT cycles. It pulses ERR together with ACK.
//   Undefined - SEND waits for TX_DONE indefinitely and ERR is tied to 0.
// -----------------------------------------------------------------------------
module rs232_tx_arbiter #(
   parameter int unsigned TIMEOUT = 20000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [3:0]  REQ,
   input  logic [31:0] DATA,
   output logic [3:0]  ACK,
   output logic [1:0]  GNT,
   output logic        BUSY,
   output logic        ERR,
   output logic [7:0]  TX_DATA,
   output logic        TX_WR_EN,
   input  logic        TX_DONE
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SEND    = 2'd1,
      RELEASE = 2'd2
   } state_t;

   if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_timeout_range
      $error("rs232_tx_arbiter: TIMEOUT must lie in 2..65535");
   end

   state_t      state_q, state_d;
   logic [1:0]  last_q, last_d;
   logic [1:0]  pick;
   logic [3:0]  ack_d;
   logic [1:0]  gnt_d;
   logic        busy_d;
   logic        wr_en_d;
   logic [7:0]  data_d;
   logic        timeout_hit;

   // Round robin: the first requester set when scanning last+1, last+2, ...
   // modulo 4. The scan runs backwards so the closest candidate is written
   // last and wins. Offset 4 wraps back to 'last' itself, which makes it the
   // final fallback.
   function automatic logic [1:0] rr_pick(input logic [3:0] req,
                                          input logic [1:0] last);
      logic [1:0] idx;
      rr_pick = last;
      for (int off = 4; off >= 1; off--) begin
         idx = last + 2'(off);
         if (req[idx]) rr_pick = idx;
      end
   endfunction

   assign pick = rr_pick(REQ, last_q);

`ifdef RS232_ARB_TIMEOUT_EN
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

   logic [15:0] cnt_q;

   // SEND is only ever entered from IDLE. Holding the counter at zero in IDLE
   // therefore clears it on entry to SEND.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_q <= '0;
      end else if (state_q == IDLE) begin
         cnt_q <= '0;
      end else if (state_q == SEND) begin
         cnt_q <= cnt_q + 16'd1;
      end
   end

   assign timeout_hit = (state_q == SEND) && (cnt_q == TIMEOUT_LAST);

   // When DONE arrives in the same cycle as the timeout, DONE wins and the
   // frame is treated as a normal completion.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ERR <= 1'b0;
      end else begin
         ERR <= timeout_hit && !TX_DONE;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign ERR         = 1'b0;
`endif

   // NOTE: every output of this block gets a default before the case
   // statement. A path that leaves a variable unassigned would infer a latch.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      ack_d   = '0;
      gnt_d   = GNT;
      busy_d  = BUSY;
      wr_en_d = TX_WR_EN;
      data_d  = TX_DATA;

      unique case (state_q)
         IDLE: begin
            if (REQ != '0) begin
               data_d  = DATA[{pick, 3'b000} +: 8];
               gnt_d   = pick;
               wr_en_d = 1'b1;
               busy_d  = 1'b1;
               state_d = SEND;
            end
         end
         SEND: begin
            if (TX_DONE || timeout_hit) begin
               wr_en_d = 1'b0;
               ack_d   = 4'b0001 << GNT;
               last_d  = GNT;
               state_d = RELEASE;
            end
         end
         RELEASE: begin
            // Wait until DONE drops, so that a DONE level left over from the
            // previous frame cannot complete the next byte.
            if (!TX_DONE) begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments, so every register
   // samples the values from before this clock edge.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= IDLE;
         last_q   <= 2'd3;
         ACK      <= '0;
         GNT      <= '0;
         BUSY     <= 1'b0;
         TX_DATA  <= '0;
         TX_WR_EN <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         ACK      <= ack_d;
         GNT      <= gnt_d;
         BUSY     <= busy_d;
         TX_DATA  <= data_d;
         TX_WR_EN <= wr_en_d;
      end
   end

endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rs232_tx_arbiter
//
// Self-checking bench for rs232_tx_arbiter. The bench plays both sides of the
// arbiter:
//   - the four requesters, which raise REQ and drop it on their ACK;
//   - the rs232_tx transmitter, which answers TX_WR_EN with a DONE level after
//     a random delay.
// A reference model tracks the pending set and the last owner. It predicts
// the winner, the byte sent and the acknowledge of every frame.
// -----------------------------------------------------------------------------
module tb_rs232_tx_arbiter;

   logic        CLK = 1'b0;
   logic        RST;
   logic [3:0]  REQ;
   logic [31:0] DATA;
   logic        TX_DONE;
   logic [3:0]  ACK;
   logic [1:0]  GNT;
   logic        BUSY;
   logic        ERR;
   logic [7:0]  TX_DATA;
   logic        TX_WR_EN;

   rs232_tx_arbiter #(.TIMEOUT(8)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .REQ      (REQ),
      .DATA     (DATA),
      .ACK      (ACK),
      .GNT      (GNT),
      .BUSY     (BUSY),
      .ERR      (ERR),
      .TX_DATA  (TX_DATA),
      .TX_WR_EN (TX_WR_EN),
      .TX_DONE  (TX_DONE)
   );

   always #5 CLK = ~CLK;

   int n_tests    = 0;
   int n_fail     = 0;
   int model_last = 3;

   // Observations of one frame, collected by serve_one.
   typedef struct {
      bit         granted;
      int         lat;
      int         gnt;
      logic [7:0] byte_v;
      logic       busy_at_grant;
      bit         send_bad;
      logic [3:0] ack;
      logic       wr_after;
      logic       err_at_ack;
      bit         release_bad;
      logic       busy_after;
      logic [3:0] ack_after;
   } frame_obs_t;

   // Reference rule: the first pending requester after 'last', modulo 4.
   function automatic int rr_expect(input logic [3:0] pend, input int last);
      for (int k = 1; k <= 4; k++) begin
         int i = (last + k) % 4;
         if (pend[i]) return i;
      end
      return -1;
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RST     = 1'b1;
      REQ     = '0;
      TX_DONE = 1'b0;
      repeat (2) tick();
      RST = 1'b0;
      tick();
      model_last = 3;
   endtask

   // Runs one complete frame:
   //   1. wait (bounded) for a grant;
   //   2. hold DONE low for done_dly cycles;
   //   3. raise DONE and keep it high for rel_dly cycles after the ACK;
   //   4. drop DONE.
   // The granted requester drops its REQ when it sees ACK.
   task automatic serve_one(input int done_dly, input int rel_dly,
                            output frame_obs_t o);
      o.granted = 0; o.lat = 0; o.gnt = 0; o.byte_v = '0;
      o.busy_at_grant = 1'b0; o.send_bad = 0; o.ack = '0;
      o.wr_after = 1'b1; o.err_at_ack = 1'b0; o.release_bad = 0;
      o.busy_after = 1'b1; o.ack_after = '0;
      do begin
         tick();
         o.lat++;
      end while (TX_WR_EN !== 1'b1 && o.lat < 20);
      if (TX_WR_EN !== 1'b1) return;
      o.granted       = 1;
      o.gnt           = int'(GNT);
      o.byte_v        = TX_DATA;
      o.busy_at_grant = BUSY;
      repeat (done_dly) begin
         tick();
         if (TX_WR_EN !== 1'b1 || ACK !== 4'b0 || TX_DATA !== o.byte_v ||
             BUSY !== 1'b1)
            o.send_bad = 1;
      end
      TX_DONE = 1'b1;
      tick();
      o.ack        = ACK;
      o.wr_after   = TX_WR_EN;
      o.err_at_ack = ERR;
      REQ[o.gnt]   = 1'b0;
      repeat (rel_dly) begin
         tick();
         if (ACK !== 4'b0 || TX_WR_EN !== 1'b0 || BUSY !== 1'b1)
            o.release_bad = 1;
      end
      TX_DONE = 1'b0;
      tick();
      o.busy_after = BUSY;
      o.ack_after  = ACK;
   endtask

   task automatic test_reset();
      RST = 1'b1; REQ = '0; DATA = '0; TX_DONE = 1'b0;
      #3;
      n_tests++;
      if (ACK !== 4'b0 || GNT !== 2'b0 || BUSY !== 1'b0 || ERR !== 1'b0 ||
          TX_DATA !== 8'h0 || TX_WR_EN !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: ack=%b gnt=%0d busy=%b err=%b txd=%h wr=%b, all must be 0",
                  ACK, GNT, BUSY, ERR, TX_DATA, TX_WR_EN);
      end
      do_reset();
      repeat (3) tick();
      n_tests++;
      if (BUSY !== 1'b0 || TX_WR_EN !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_no_req: busy=%b wr=%b, required 0 0", BUSY, TX_WR_EN);
      end
   endtask

   task automatic test_single();
      frame_obs_t o;
      DATA = {$urandom(), 8'hD2} >> 0;
      DATA[7:0] = 8'hD2;
      REQ = 4'b0001;
      serve_one(10, 0, o);
      n_tests++;
      if (!o.granted || o.lat != 1 || o.gnt != 0 || o.byte_v !== 8'hD2 ||
          o.busy_at_grant !== 1'b1) begin
         n_fail++;
         $display("FAIL single_grant: granted=%0d lat=%0d gnt=%0d byte=%h busy=%b, required 1 1 0 d2 1",
                  o.granted, o.lat, o.gnt, o.byte_v, o.busy_at_grant);
      end
      n_tests++;
      if (o.send_bad || o.ack !== 4'b0001 || o.wr_after !== 1'b0) begin
         n_fail++;
         $display("FAIL single_ack: send_bad=%0d ack=%b wr=%b, required 0 0001 0",
                  o.send_bad, o.ack, o.wr_after);
      end
      n_tests++;
      if (o.busy_after !== 1'b0 || o.ack_after !== 4'b0) begin
         n_fail++;
         $display("FAIL single_release: busy=%b ack=%b, required 0 0000",
                  o.busy_after, o.ack_after);
      end
      model_last = 0;
   endtask

   task automatic test_all_four();
      frame_obs_t o;
      int exp_i;
      do_reset();
      DATA = 32'h44332211;
      REQ  = 4'b1111;
      for (int f = 0; f < 4; f++) begin
         exp_i = rr_expect(REQ, model_last);
         serve_one($urandom_range(1, 12), $urandom_range(0, 3), o);
         n_tests++;
         if (!o.granted || o.gnt != exp_i || o.byte_v !== DATA[8*exp_i +: 8] ||
             o.ack !== (4'b0001 << exp_i)) begin
            n_fail++;
            $display("FAIL all_four_frame%0d: gnt=%0d byte=%h ack=%b, required gnt=%0d byte=%h ack=%b",
                     f, o.gnt, o.byte_v, o.ack, exp_i, DATA[8*exp_i +: 8],
                     4'b0001 << exp_i);
         end
         n_tests++;
         if (o.release_bad || o.send_bad || o.busy_after !== 1'b0) begin
            n_fail++;
            $display("FAIL all_four_proto%0d: release_bad=%0d send_bad=%0d busy=%b, required 0 0 0",
                     f, o.release_bad, o.send_bad, o.busy_after);
         end
         model_last = exp_i;
      end
   endtask

   task automatic test_round_robin();
      frame_obs_t o;
      DATA = $urandom();
      REQ  = 4'b0100;
      serve_one(3, 0, o);
      n_tests++;
      if (o.gnt != 2 || o.ack !== 4'b0100) begin
         n_fail++;
         $display("FAIL rr_first: gnt=%0d ack=%b, required 2 0100", o.gnt, o.ack);
      end
      model_last = 2;
      REQ = 4'b1001;
      serve_one(2, 1, o);
      n_tests++;
      if (o.gnt != 3 || o.ack !== 4'b1000 || o.byte_v !== DATA[31:24]) begin
         n_fail++;
         $display("FAIL rr_three_before_zero: gnt=%0d ack=%b byte=%h, required 3 1000 %h",
                  o.gnt, o.ack, o.byte_v, DATA[31:24]);
      end
      serve_one(2, 0, o);
      n_tests++;
      if (o.gnt != 0 || o.ack !== 4'b0001 || o.lat != 1) begin
         n_fail++;
         $display("FAIL rr_then_zero: gnt=%0d ack=%b lat=%0d, required 0 0001 1",
                  o.gnt, o.ack, o.lat);
      end
      model_last = 0;
   endtask

   task automatic test_reset_mid();
      frame_obs_t o;
      int exp_i;
      DATA = $urandom();
      REQ  = 4'b0010;
      tick();
      n_tests++;
      if (TX_WR_EN !== 1'b1 || GNT !== 2'd1) begin
         n_fail++;
         $display("FAIL reset_mid_grant: wr=%b gnt=%0d, required 1 1", TX_WR_EN, GNT);
      end
      repeat (3) tick();
      #2 RST = 1'b1;
      #1;
      n_tests++;
      if (TX_WR_EN !== 1'b0 || BUSY !== 1'b0 || ACK !== 4'b0 || GNT !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_mid_async: wr=%b busy=%b ack=%b gnt=%0d, required 0 0 0000 0",
                  TX_WR_EN, BUSY, ACK, GNT);
      end
      REQ  = 4'b1111;
      DATA = $urandom();
      tick();
      tick();
      RST = 1'b0;
      model_last = 3;
      for (int f = 0; f < 4; f++) begin
         exp_i = rr_expect(REQ, model_last);
         serve_one($urandom_range(0, 6), $urandom_range(0, 2), o);
         n_tests++;
         if (o.gnt != exp_i || o.ack !== (4'b0001 << exp_i) ||
             o.byte_v !== DATA[8*exp_i +: 8] || (f == 0 && o.gnt != 0)) begin
            n_fail++;
            $display("FAIL reset_mid_after%0d: gnt=%0d ack=%b byte=%h, required gnt=%0d",
                     f, o.gnt, o.ack, o.byte_v, exp_i);
         end
         model_last = exp_i;
      end
   endtask

   task automatic test_early_drop();
      logic [7:0] orig;
      bit         bad;
      bad  = 0;
      DATA = $urandom();
      orig = DATA[15:8];
      REQ  = 4'b0010;
      tick();
      n_tests++;
      if (TX_WR_EN !== 1'b1 || GNT !== 2'd1 || TX_DATA !== orig) begin
         n_fail++;
         $display("FAIL early_drop_grant: wr=%b gnt=%0d txd=%h, required 1 1 %h",
                  TX_WR_EN, GNT, TX_DATA, orig);
      end
      tick();
      REQ = 4'b0000;
      DATA[15:8] = ~orig;
      repeat (5) begin
         tick();
         if (TX_DATA !== orig || TX_WR_EN !== 1'b1) bad = 1;
      end
      n_tests++;
      if (bad) begin
         n_fail++;
         $display("FAIL early_drop_hold: txd=%h wr=%b, required %h 1", TX_DATA, TX_WR_EN, orig);
      end
      TX_DONE = 1'b1;
      tick();
      n_tests++;
      if (ACK !== 4'b0010 || TX_WR_EN !== 1'b0) begin
         n_fail++;
         $display("FAIL early_drop_ack: ack=%b wr=%b, required 0010 0", ACK, TX_WR_EN);
      end
      TX_DONE = 1'b0;
      tick();
      n_tests++;
      if (BUSY !== 1'b0 || ACK !== 4'b0) begin
         n_fail++;
         $display("FAIL early_drop_release: busy=%b ack=%b, required 0 0000", BUSY, ACK);
      end
      model_last = 1;
   endtask

   // Random requester traffic. Requesters that just got their ACK may re-raise
   // at once; the model then queues them behind the others.
   task automatic test_random_traffic();
      frame_obs_t o;
      int exp_i;
      int r;
      logic [7:0] exp_b;
      for (int it = 0; it < 30; it++) begin
         for (int i = 0; i < 4; i++) begin
            if (!REQ[i] && $urandom_range(0, 1) == 1) begin
               DATA[8*i +: 8] = 8'($urandom());
               REQ[i] = 1'b1;
            end
         end
         if (REQ == 4'b0) begin
            r = $urandom_range(0, 3);
            DATA[8*r +: 8] = 8'($urandom());
            REQ[r] = 1'b1;
         end
         exp_i = rr_expect(REQ, model_last);
         exp_b = DATA[8*exp_i +: 8];
         serve_one($urandom_range(0, 8), $urandom_range(0, 3), o);
         n_tests++;
         if (!o.granted || o.lat != 1 || o.busy_at_grant !== 1'b1) begin
            n_fail++;
            $display("FAIL rand_grant%0d: granted=%0d lat=%0d busy=%b, required 1 1 1",
                     it, o.granted, o.lat, o.busy_at_grant);
         end
         n_tests++;
         if (o.gnt != exp_i || o.byte_v !== exp_b || o.ack !== (4'b0001 << exp_i)) begin
            n_fail++;
            $display("FAIL rand_frame%0d: gnt=%0d byte=%h ack=%b, required gnt=%0d byte=%h ack=%b",
                     it, o.gnt, o.byte_v, o.ack, exp_i, exp_b, 4'b0001 << exp_i);
         end
         n_tests++;
         if (o.send_bad || o.wr_after !== 1'b0 || o.err_at_ack !== 1'b0 ||
             o.release_bad || o.busy_after !== 1'b0 || o.ack_after !== 4'b0) begin
            n_fail++;
            $display("FAIL rand_proto%0d: send_bad=%0d wr=%b err=%b rel_bad=%0d busy=%b ack_after=%b, required 0 0 0 0 0 0000",
                     it, o.send_bad, o.wr_after, o.err_at_ack, o.release_bad,
                     o.busy_after, o.ack_after);
         end
         model_last = exp_i;
      end
      REQ = 4'b0;
   endtask

`ifdef RS232_ARB_TIMEOUT_EN
   task automatic test_timeout();
      int  r;
      bit  bad;
      bad = 0;
      r   = $urandom_range(0, 3);
      DATA = $urandom();
      REQ  = 4'b0001 << r;
      tick();
      n_tests++;
      if (TX_WR_EN !== 1'b1 || GNT !== 2'(r)) begin
         n_fail++;
         $display("FAIL timeout_grant: wr=%b gnt=%0d, required 1 %0d", TX_WR_EN, GNT, r);
      end
      for (int j = 1; j <= 8; j++) begin
         tick();
         if (j < 8) begin
            if (ERR !== 1'b0 || ACK !== 4'b0 || TX_WR_EN !== 1'b1) bad = 1;
         end else begin
            n_tests++;
            if (ERR !== 1'b1 || ACK !== (4'b0001 << r) || TX_WR_EN !== 1'b0) begin
               n_fail++;
               $display("FAIL timeout_fire: err=%b ack=%b wr=%b, required 1 %b 0",
                        ERR, ACK, TX_WR_EN, 4'b0001 << r);
            end
         end
      end
      n_tests++;
      if (bad) begin
         n_fail++;
         $display("FAIL timeout_early: err/ack moved or wr dropped before cycle 8");
      end
      REQ = 4'b0;
      tick();
      n_tests++;
      if (ERR !== 1'b0 || ACK !== 4'b0 || BUSY !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_release: err=%b ack=%b busy=%b, required 0 0000 0",
                  ERR, ACK, BUSY);
      end
      model_last = r;
   endtask
`else
   task automatic test_timeout();
      int  r;
      bit  bad;
      bad = 0;
      r   = $urandom_range(0, 3);
      REQ = 4'b0001 << r;
      tick();
      repeat (30) begin
         tick();
         if (ERR !== 1'b0 || TX_WR_EN !== 1'b1 || ACK !== 4'b0) bad = 1;
      end
      n_tests++;
      if (bad) begin
         n_fail++;
         $display("FAIL no_timeout_wait: frame abandoned or err raised without the option");
      end
      TX_DONE = 1'b1;
      tick();
      n_tests++;
      if (ACK !== (4'b0001 << r) || ERR !== 1'b0) begin
         n_fail++;
         $display("FAIL no_timeout_ack: ack=%b err=%b, required %b 0", ACK, ERR, 4'b0001 << r);
      end
      REQ = 4'b0;
      TX_DONE = 1'b0;
      tick();
      n_tests++;
      if (BUSY !== 1'b0) begin
         n_fail++;
         $display("FAIL no_timeout_release: busy=%b, required 0", BUSY);
      end
      model_last = r;
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_single();
      test_all_four();
      test_round_robin();
      test_reset_mid();
      test_early_drop();
      test_random_traffic();
      test_timeout();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
